dram_arbiter: RTL and testbench
===============================

Name: dram_arbiter

Overview:
- Two-requester arbiter sharing the single DRAM user interface (ren/wen/addr/data/mask/busy/rdata/rdata_valid) between port 0 (data side) and port 1 (instruction-cache fill side).
- Sits between the core memory subsystem and the DRAM wrapper, in the DRAM user clock domain.
- Serialises transactions: one command outstanding at a time. Read data is routed back to the issuing port. A read timeout protects against a lost response.

Parameters:
- APP_ADDR_WIDTH, 28: DRAM app address width; request/DRAM address buses are APP_ADDR_WIDTH-1 bits.
- APP_DATA_WIDTH, 128: data beat width.
- APP_MASK_WIDTH, 16: byte-mask width, APP_DATA_WIDTH/8.
- TIMEOUT_CYCLES, 1023: maximum cycles spent in RWAIT before abort; counter width is $clog2(TIMEOUT_CYCLES+1).

Ports:
- clock  in  1  sole clock (DRAM user clock)
- resetn  in  1  asynchronous active-low reset
- p0_req, p1_req  in  1  request valid; held with fields stable until pN_ack
- p0_wen, p1_wen  in  1  1 = write, 0 = read
- p0_addr, p1_addr  in  APP_ADDR_WIDTH-1  beat address
- p0_wdata, p1_wdata  in  APP_DATA_WIDTH  write data
- p0_wmask, p1_wmask  in  APP_MASK_WIDTH  byte mask, passed through unmodified
- p0_ack, p1_ack  out  1  one-cycle pulse: request accepted by DRAM
- p0_rdata, p1_rdata  out  APP_DATA_WIDTH  read data, valid with pN_rvalid
- p0_rvalid, p1_rvalid  out  1  one-cycle read-data strobe
- p0_rerr, p1_rerr  out  1  one-cycle pulse: read timed out, rdata = 0
- dram_ren, dram_wen  out  1  DRAM command strobes
- dram_addr  out  APP_ADDR_WIDTH-1  command address
- dram_wdata  out  APP_DATA_WIDTH  write data
- dram_wmask  out  APP_MASK_WIDTH  write mask
- dram_busy  in  1  DRAM cannot accept a command this cycle
- dram_init_calib_complete  in  1  calibration done
- dram_rdata  in  APP_DATA_WIDTH  read data
- dram_rdata_valid  in  1  read data strobe

Behaviour:
- Reset (resetn low, asynchronous):
  - State goes to IDLE.
  - All outputs are 0, including latched command registers.
  - Owner register is 0 and the timeout counter is 0.
  - The RR pointer (if present) points to port 0.
- FSM states: IDLE, CMD, RWAIT.
- IDLE: grant only if dram_init_calib_complete=1 and some pN_req=1.
  - The winner's wen/addr/wdata/wmask are latched into the command registers and the owner is recorded.
  - Next state is CMD.
  - No grant while calibration is incomplete; requests simply wait.
- CMD:
  - dram_ren = ~latched_wen and dram_wen = latched_wen; both are driven from registers.
  - The command is accepted in the first CMD cycle where dram_busy=0.
  - In that same cycle pOwner_ack=1 for one cycle. The requester may drop or change req from the next cycle.
  - After acceptance, a write goes to IDLE and a read goes to RWAIT with the counter cleared.
  - Strobes deassert in the cycle after acceptance. The command is held indefinitely while busy=1.
- RWAIT:
  - pOwner_rdata = dram_rdata and pOwner_rvalid = dram_rdata_valid, combinationally, for one cycle. Then go to IDLE.
  - The non-owner's rvalid stays 0 and its rdata stays 0.
  - The counter increments each cycle without rdata_valid. When it reaches TIMEOUT_CYCLES: pOwner_rerr pulses, go to IDLE, and clear the counter.
  - If rdata_valid arrives in the same cycle the counter reaches TIMEOUT_CYCLES, the data wins and no rerr is raised.
- dram_rdata_valid outside RWAIT is ignored (stale response after a timeout or reset).
- Minimum turnaround:
  - Write: grant cycle plus 1 CMD cycle, so a back-to-back write every 2 cycles.
  - Read: 2 cycles plus DRAM latency plus 1 return cycle.
- Arbitration without RR: fixed priority, port 0 wins when both request in IDLE.
- A request is never granted twice: ack is exactly one pulse per accepted transaction.
- Reset during CMD or RWAIT abandons the transaction with no ack and no rvalid; the DRAM wrapper is reset in the same domain.

Optional Feature:
- Macro DRAM_ARB_ROUND_ROBIN_EN.
- Defined: a 1-bit last-grant pointer is kept. On simultaneous requests, the port not granted last wins; the pointer updates at each grant. A single requester always wins regardless of the pointer.
- Undefined: fixed priority, port 0 first, and no pointer flop exists.

Decomposition:
- Shared package dram_arb_pkg:
  - typedef enum logic [1:0] {IDLE, CMD, RWAIT} dram_arb_state_t
  - typedef struct dram_arb_req_t {wen, addr, wdata, wmask}
  - localparam NUM_PORTS = 2
- One sub-module is natural: dram_arb_pick, a combinational winner select taking the req vector and pointer.
- The FSM, command registers and timeout counter stay in the top module.

Test Plan:
- Calibration gating: p0 read req at addr 0x0000100 held with calib=0 for 20 cycles, then calib=1.
  - No dram_ren during the 20 cycles; dram_ren with addr 0x0000100 two cycles after calib rises.
- Write with busy stall: p1 write, addr 0x0123456, wdata 0xDEADBEEF_..., wmask 0x0000, dram_busy=1 for 5 CMD cycles.
  - dram_wen held 6 cycles with stable fields; p1_ack pulses once, in the cycle busy=0; state returns to IDLE.
- Read routing: p1 read, DRAM returns rdata 0xA5A5...A5 after 12 cycles.
  - p1_rvalid=1 for one cycle with that data; p0_rvalid=0 and p0_rdata=0.
- Contention: p0 and p1 both write continuously for 8 transactions.
  - Fixed priority: 8 grants to p0, 0 to p1.
  - With DRAM_ARB_ROUND_ROBIN_EN: grants alternate p0, p1, p0, ... (4 each).
- Timeout: TIMEOUT_CYCLES=16, p0 read, no rdata_valid.
  - p0_rerr pulses 16 cycles after acceptance with p0_rdata=0.
  - A later rdata_valid is ignored; a following p1 read completes normally.
- Reset mid-read: resetn low for 3 cycles while in RWAIT.
  - All outputs 0 immediately (asynchronously); no rvalid on release; next request is granted from IDLE.

Source files
------------

// File: rtl/dram_arb_pkg.sv
// dram_arb_pkg: shared types and constants for the two-port DRAM arbiter.
//   dram_arb_state_t : arbiter FSM states
//   dram_arb_req_t   : request payload at the default bus widths
//   NUM_PORTS        : number of requesters
package dram_arb_pkg;

  localparam int unsigned NUM_PORTS          = 2;
  localparam int unsigned APP_ADDR_WIDTH_DEF = 28;
  localparam int unsigned APP_DATA_WIDTH_DEF = 128;
  localparam int unsigned APP_MASK_WIDTH_DEF = APP_DATA_WIDTH_DEF / 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CMD   = 2'd1,
    RWAIT = 2'd2
  } dram_arb_state_t;

  typedef struct packed {
    logic                            wen;
    logic [APP_ADDR_WIDTH_DEF-2:0]   addr;
    logic [APP_DATA_WIDTH_DEF-1:0]   wdata;
    logic [APP_MASK_WIDTH_DEF-1:0]   wmask;
  } dram_arb_req_t;

endpackage

// File: rtl/dram_arb_pick.sv
// dram_arb_pick: combinational winner select for the two requesters.
//   req      : request vector, bit N = port N
//   ptr      : port that wins when both request
//   grant_c  : some port is requesting
//   winner_c : index of the winning port (only meaningful with grant_c)
module dram_arb_pick
  import dram_arb_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req,
  input  logic                 ptr,
  output logic                 grant_c,
  output logic                 winner_c
);

  // A lone requester always wins; the pointer only breaks ties.
  always_comb begin
    grant_c  = |req;
    winner_c = 1'b0;
    if (req[0] && req[1]) begin
      winner_c = ptr;
    end else if (req[1]) begin
      winner_c = 1'b1;
    end
  end

endmodule

// File: rtl/dram_arbiter.sv
// dram_arbiter: shares one DRAM user interface between port 0 (data) and
// port 1 (instruction fill). One command outstanding at a time; read data
// is routed to the issuing port; a read timeout recovers a lost response.
//   clock/resetn        : DRAM user clock, async active-low reset
//   pN_req/wen/addr/... : requester command, held until pN_ack
//   pN_ack              : command accepted by DRAM (combinational pulse)
//   pN_rdata/rvalid     : read return, combinational from the DRAM side
//   pN_rerr             : read timed out (combinational pulse, rdata = 0)
//   dram_*              : DRAM wrapper command / response interface
// Build option: DRAM_ARB_ROUND_ROBIN_EN selects round-robin arbitration
// instead of fixed priority (port 0 first).
module dram_arbiter
  import dram_arb_pkg::*;
#(
  parameter int unsigned APP_ADDR_WIDTH = 28,
  parameter int unsigned APP_DATA_WIDTH = 128,
  parameter int unsigned APP_MASK_WIDTH = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic                      clock,
  input  logic                      resetn,
  input  logic                      p0_req,
  input  logic                      p0_wen,
  input  logic [APP_ADDR_WIDTH-2:0] p0_addr,
  input  logic [APP_DATA_WIDTH-1:0] p0_wdata,
  input  logic [APP_MASK_WIDTH-1:0] p0_wmask,
  output logic                      p0_ack,
  output logic [APP_DATA_WIDTH-1:0] p0_rdata,
  output logic                      p0_rvalid,
  output logic                      p0_rerr,
  input  logic                      p1_req,
  input  logic                      p1_wen,
  input  logic [APP_ADDR_WIDTH-2:0] p1_addr,
  input  logic [APP_DATA_WIDTH-1:0] p1_wdata,
  input  logic [APP_MASK_WIDTH-1:0] p1_wmask,
  output logic                      p1_ack,
  output logic [APP_DATA_WIDTH-1:0] p1_rdata,
  output logic                      p1_rvalid,
  output logic                      p1_rerr,
  output logic                      dram_ren,
  output logic                      dram_wen,
  output logic [APP_ADDR_WIDTH-2:0] dram_addr,
  output logic [APP_DATA_WIDTH-1:0] dram_wdata,
  output logic [APP_MASK_WIDTH-1:0] dram_wmask,
  input  logic                      dram_busy,
  input  logic                      dram_init_calib_complete,
  input  logic [APP_DATA_WIDTH-1:0] dram_rdata,
  input  logic                      dram_rdata_valid
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  dram_arb_state_t state_q, state_d;
  logic            owner_q;
  logic [CNT_W-1:0] cnt_q;
  logic            rr_ptr;
  logic            pick_grant_c, pick_winner_c;
  logic            grant_c, accept_c, rsp_c, timeout_c;

  logic                      win_wen;
  logic [APP_ADDR_WIDTH-2:0] win_addr;
  logic [APP_DATA_WIDTH-1:0] win_wdata;
  logic [APP_MASK_WIDTH-1:0] win_wmask;

`ifdef DRAM_ARB_ROUND_ROBIN_EN
  // Pointer holds the port that wins the next tie; flips away from each winner.
  logic rr_ptr_q;
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rr_ptr_q <= 1'b0;
    end else if (grant_c) begin
      rr_ptr_q <= ~pick_winner_c;
    end
  end
  assign rr_ptr = rr_ptr_q;
`else
  assign rr_ptr = 1'b0;
`endif

  dram_arb_pick u_pick (
    .req      ({p1_req, p0_req}),
    .ptr      (rr_ptr),
    .grant_c  (pick_grant_c),
    .winner_c (pick_winner_c)
  );

  // Winning request fields
  always_comb begin
    win_wen   = pick_winner_c ? p1_wen   : p0_wen;
    win_addr  = pick_winner_c ? p1_addr  : p0_addr;
    win_wdata = pick_winner_c ? p1_wdata : p0_wdata;
    win_wmask = pick_winner_c ? p1_wmask : p0_wmask;
  end

  // State register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and per-port handshake/response outputs
  always_comb begin
    state_d   = state_q;
    grant_c   = 1'b0;
    accept_c  = 1'b0;
    rsp_c     = 1'b0;
    timeout_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (dram_init_calib_complete && pick_grant_c) begin
          grant_c = 1'b1;
          state_d = CMD;
        end
      end
      CMD: begin
        // dram_wen mirrors the latched command type while in CMD
        if (!dram_busy) begin
          accept_c = 1'b1;
          state_d  = dram_wen ? IDLE : RWAIT;
        end
      end
      RWAIT: begin
        // Data arriving on the last allowed cycle takes precedence over the timeout
        if (dram_rdata_valid) begin
          rsp_c   = 1'b1;
          state_d = IDLE;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          timeout_c = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    p0_ack    = accept_c & ~owner_q;
    p1_ack    = accept_c &  owner_q;
    p0_rvalid = rsp_c & ~owner_q;
    p1_rvalid = rsp_c &  owner_q;
    p0_rerr   = timeout_c & ~owner_q;
    p1_rerr   = timeout_c &  owner_q;
    p0_rdata  = p0_rvalid ? dram_rdata : '0;
    p1_rdata  = p1_rvalid ? dram_rdata : '0;
  end

  // Command registers, owner and read timeout counter
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      owner_q    <= 1'b0;
      dram_ren   <= 1'b0;
      dram_wen   <= 1'b0;
      dram_addr  <= '0;
      dram_wdata <= '0;
      dram_wmask <= '0;
      cnt_q      <= '0;
    end else begin
      if (grant_c) begin
        owner_q    <= pick_winner_c;
        dram_ren   <= ~win_wen;
        dram_wen   <= win_wen;
        dram_addr  <= win_addr;
        dram_wdata <= win_wdata;
        dram_wmask <= win_wmask;
      end
      if (accept_c) begin
        dram_ren <= 1'b0;
        dram_wen <= 1'b0;
        cnt_q    <= '0;
      end else if (state_q == RWAIT) begin
        cnt_q <= (rsp_c || timeout_c) ? '0 : cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_dram_arbiter.sv
// tb_dram_arbiter: self-checking bench for dram_arbiter (TIMEOUT_CYCLES = 16).
// Table-driven single-port transactions plus hand-written sequences for
// calibration gating, timeout, reset during a read and contention.
module tb_dram_arbiter;
  import dram_arb_pkg::*;

  localparam int unsigned TO = 16;

  logic         clock, resetn;
  logic         p0_req, p0_wen, p1_req, p1_wen;
  logic [26:0]  p0_addr, p1_addr, dram_addr;
  logic [127:0] p0_wdata, p1_wdata, p0_rdata, p1_rdata, dram_wdata, dram_rdata;
  logic [15:0]  p0_wmask, p1_wmask, dram_wmask;
  logic         p0_ack, p0_rvalid, p0_rerr, p1_ack, p1_rvalid, p1_rerr;
  logic         dram_ren, dram_wen, dram_busy, calib, dram_rdata_valid;

  dram_arbiter #(
    .APP_ADDR_WIDTH (28),
    .APP_DATA_WIDTH (128),
    .APP_MASK_WIDTH (16),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clock (clock), .resetn (resetn),
    .p0_req (p0_req), .p0_wen (p0_wen), .p0_addr (p0_addr), .p0_wdata (p0_wdata),
    .p0_wmask (p0_wmask), .p0_ack (p0_ack), .p0_rdata (p0_rdata),
    .p0_rvalid (p0_rvalid), .p0_rerr (p0_rerr),
    .p1_req (p1_req), .p1_wen (p1_wen), .p1_addr (p1_addr), .p1_wdata (p1_wdata),
    .p1_wmask (p1_wmask), .p1_ack (p1_ack), .p1_rdata (p1_rdata),
    .p1_rvalid (p1_rvalid), .p1_rerr (p1_rerr),
    .dram_ren (dram_ren), .dram_wen (dram_wen), .dram_addr (dram_addr),
    .dram_wdata (dram_wdata), .dram_wmask (dram_wmask), .dram_busy (dram_busy),
    .dram_init_calib_complete (calib), .dram_rdata (dram_rdata),
    .dram_rdata_valid (dram_rdata_valid)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    bit            port;
    dram_arb_req_t req;
    int            busy_n;   // CMD cycles with busy held high
    int            lat;      // cycles from acceptance to rdata_valid (0: no return)
    logic [127:0]  rdata;
  } vec_t;

  typedef struct {
    logic [3:0]   flags;     // {p1_rerr, p0_rerr, p1_rvalid, p0_rvalid}
    logic [127:0] rd0;
    logic [127:0] rd1;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_ack0  = 0;
  int   n_ack1  = 0;

  logic         s_ren, s_wen, s_ack0, s_ack1, s_rv0, s_rv1, s_re0, s_re1;
  logic [26:0]  s_addr;
  logic [127:0] s_wdata;
  logic [15:0]  s_wmask;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Sample outputs mid-cycle and check any read response against the scoreboard
  task automatic monitor();
    exp_t       e;
    logic [3:0] fl;
    s_ren = dram_ren;  s_wen = dram_wen;  s_addr = dram_addr;
    s_wdata = dram_wdata;  s_wmask = dram_wmask;
    s_ack0 = p0_ack;  s_ack1 = p1_ack;
    s_rv0 = p0_rvalid;  s_rv1 = p1_rvalid;  s_re0 = p0_rerr;  s_re1 = p1_rerr;
    if (p0_ack) n_ack0++;
    if (p1_ack) n_ack1++;
    fl = {p1_rerr, p0_rerr, p1_rvalid, p0_rvalid};
    if (fl != 4'b0000) begin
      if (sb.size() == 0) begin
        chki("unexpected_rsp", int'(fl), 0);
      end else begin
        e = sb.pop_front();
        chki("rsp_flags", int'(fl), int'(e.flags));
        chk("rsp_rdata0", p0_rdata, e.rd0);
        chk("rsp_rdata1", p1_rdata, e.rd1);
      end
    end
  endtask

  task automatic step();
    @(negedge clock);
    monitor();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input bit port, input bit on, input dram_arb_req_t r);
    if (port) begin
      p1_req = on; p1_wen = r.wen; p1_addr = r.addr; p1_wdata = r.wdata; p1_wmask = r.wmask;
    end else begin
      p0_req = on; p0_wen = r.wen; p0_addr = r.addr; p0_wdata = r.wdata; p0_wmask = r.wmask;
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chki({tag, "_strobes"}, int'({dram_ren, dram_wen, p0_ack, p1_ack,
                                  p0_rvalid, p1_rvalid, p0_rerr, p1_rerr}), 0);
    chk({tag, "_addr"}, 128'(dram_addr), '0);
    chk({tag, "_wdata"}, dram_wdata, '0);
    chk({tag, "_wmask"}, 128'(dram_wmask), '0);
    chk({tag, "_rdata"}, p0_rdata | p1_rdata, '0);
  endtask

  task automatic apply_reset();
    resetn = 1'b0;
    repeat (2) step();
    resetn = 1'b1;
  endtask

  // One transaction from an idle arbiter; returns the cycle the command first shows
  task automatic do_txn(input vec_t v, output int first_strobe);
    int   a0, a1, strobes, guard;
    bit   acked, stable;
    exp_t e;
    a0 = n_ack0; a1 = n_ack1; strobes = 0; guard = 0; acked = 0; stable = 1;
    first_strobe = -1;
    set_req(v.port, 1'b1, v.req);
    dram_busy = (v.busy_n > 0);
    while (!acked && guard < 60) begin
      step();
      guard++;
      if (s_ren || s_wen) begin
        if (strobes == 0) first_strobe = guard;
        strobes++;
        if (s_ren != !v.req.wen || s_wen != v.req.wen || s_addr != v.req.addr ||
            s_wdata != v.req.wdata || s_wmask != v.req.wmask) stable = 0;
      end
      acked = v.port ? s_ack1 : s_ack0;
      dram_busy = (strobes < v.busy_n);
    end
    set_req(v.port, 1'b0, v.req);
    dram_busy = 1'b0;
    chki("ack_seen", int'(acked), 1);
    chki("cmd_cycles", strobes, v.busy_n + 1);
    chki("cmd_stable", int'(stable), 1);
    step();
    chki("strobe_drop", int'({s_ren, s_wen}), 0);
    chki("ack_once", v.port ? n_ack1 - a1 : n_ack0 - a0, 1);
    chki("ack_other", v.port ? n_ack0 - a0 : n_ack1 - a1, 0);
    if (!v.req.wen && v.lat > 0) begin
      for (int i = 2; i < v.lat; i++) step();
      dram_rdata = v.rdata;
      dram_rdata_valid = 1'b1;
      e.flags = v.port ? 4'b0010 : 4'b0001;
      e.rd0   = v.port ? '0 : v.rdata;
      e.rd1   = v.port ? v.rdata : '0;
      sb.push_back(e);
      step();
      dram_rdata_valid = 1'b0;
      dram_rdata = {4{$urandom}};
      step();
      step();
      chki("rsp_drain", sb.size(), 0);
    end else if (v.req.wen) begin
      step();
    end
  endtask

  initial begin
    vec_t          vecs[6];
    vec_t          v;
    dram_arb_req_t r, rq0, rq1;
    int            fs, seen, to_cycle, ng, last;
    bit            fields_ok;
    logic [7:0]    gseq;
    exp_t          e;

    vecs[0] = '{1'b1, '{1'b1, 27'h0123456, {4{32'hDEADBEEF}}, 16'h0000}, 5, 0, '0};
    vecs[1] = '{1'b1, '{1'b0, 27'h0000200, '0, 16'h0000}, 0, 12, {16{8'hA5}}};
    vecs[2] = '{1'b0, '{1'b1, 27'h7FFFFFF, {4{32'h13579BDF}}, 16'hFFFF}, 0, 0, '0};
    vecs[3] = '{1'b0, '{1'b0, 27'h0000000, '0, 16'h0000}, 2, 16, {4{32'h01234567}}};
    vecs[4] = '{1'b1, '{1'b1, 27'h0000001, {4{32'h55AA33CC}}, 16'h00FF}, 1, 0, '0};
    vecs[5] = '{1'b0, '{1'b0, 27'h4000000, '0, 16'h0F0F}, 0, 2, {128{1'b1}}};

    resetn = 1'b1; calib = 1'b0; dram_busy = 1'b0; dram_rdata = '0; dram_rdata_valid = 1'b0;
    r = '0;
    set_req(1'b0, 1'b0, r);
    set_req(1'b1, 1'b0, r);
    #2 resetn = 1'b0;
    #1 chk_zero_outputs("reset");
    @(posedge clock);
    #1;
    apply_reset();

    // Calibration gating: request waits until calib, command two cycles later
    r = '0;
    r.addr = 27'h0000100;
    set_req(1'b0, 1'b1, r);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (s_ren || s_wen || s_ack0 || s_ack1) seen++;
    end
    chki("calib_hold_no_cmd", seen, 0);
    calib = 1'b1;
    v = '{1'b0, r, 0, 5, {4{32'hC0FFEE00}}};
    do_txn(v, fs);
    chki("calib_first_cmd", fs, 2);

    // Table of single-port transactions
    for (int i = 0; i < 6; i++) begin
      do_txn(vecs[i], fs);
      chki($sformatf("vec%0d_first_cmd", i), fs, 2);
    end

    // Read timeout, stale response, then a normal p1 read
    r = '0;
    r.addr = 27'h0000300;
    v = '{1'b0, r, 0, 0, '0};
    do_txn(v, fs);
    e.flags = 4'b0100; e.rd0 = '0; e.rd1 = '0;
    sb.push_back(e);
    to_cycle = -1;
    dram_rdata = {4{32'hBAD0BAD0}};
    for (int k = 2; k <= 40 && to_cycle < 0; k++) begin
      step();
      if (s_re0) to_cycle = k;
    end
    chki("timeout_cycle", to_cycle, int'(TO));
    chki("timeout_popped", sb.size(), 0);
    dram_rdata_valid = 1'b1;
    step();
    chki("stale_ignored", int'({s_rv0, s_rv1}), 0);
    dram_rdata_valid = 1'b0;
    r.addr = 27'h0000304;
    v = '{1'b1, r, 0, 7, {4{32'h600DF00D}}};
    do_txn(v, fs);
    chki("post_timeout_first_cmd", fs, 2);

    // Reset while waiting for read data
    r.addr = 27'h0000400;
    v = '{1'b0, r, 0, 0, '0};
    do_txn(v, fs);
    step();
    step();
    dram_rdata = {4{32'hFEEDFACE}};
    dram_rdata_valid = 1'b1;
    #1 chki("rwait_live_rvalid", int'(p0_rvalid), 1);
    resetn = 1'b0;
    #1 chk_zero_outputs("midread_reset");
    repeat (3) step();
    resetn = 1'b1;
    step();
    chki("release_no_rvalid", int'({s_rv0, s_rv1}), 0);
    dram_rdata_valid = 1'b0;
    r = '{1'b1, 27'h0000500, {4{32'h0BADCAFE}}, 16'hF00F};
    v = '{1'b1, r, 0, 0, '0};
    do_txn(v, fs);
    chki("post_reset_first_cmd", fs, 2);

    // Contention: both ports write continuously
    apply_reset();
    rq0 = '{1'b1, 27'h0100000, {4{32'h00000000}}, 16'h0001};
    rq1 = '{1'b1, 27'h0200000, {4{32'h11111111}}, 16'h0002};
    set_req(1'b0, 1'b1, rq0);
    set_req(1'b1, 1'b1, rq1);
    gseq = '0; ng = 0; last = -1; fields_ok = 1;
    for (int cyc = 1; cyc <= 100 && ng < 8; cyc++) begin
      step();
      if (s_ack0 || s_ack1) begin
        if (s_ack0 && s_ack1) fields_ok = 0;
        if (s_addr != (s_ack1 ? rq1.addr : rq0.addr)) fields_ok = 0;
        gseq[ng] = s_ack1;
        ng++;
        last = cyc;
        if (s_ack1) begin
          rq1.addr = rq1.addr + 27'd1;
          set_req(1'b1, 1'b1, rq1);
        end else begin
          rq0.addr = rq0.addr + 27'd1;
          set_req(1'b0, 1'b1, rq0);
        end
      end
    end
    set_req(1'b0, 1'b0, rq0);
    set_req(1'b1, 1'b0, rq1);
    chki("cont_grants", ng, 8);
    chki("cont_last_ack_cycle", last, 16);
    chki("cont_fields", int'(fields_ok), 1);
`ifdef DRAM_ARB_ROUND_ROBIN_EN
    chki("cont_order", int'(gseq), 32'hAA);
`else
    chki("cont_order", int'(gseq), 0);
`endif
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
